// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The operand width is cut into STAGES segments. Each segment is resolved by one
// pipeline stage made of 4-bit lookahead groups. An input rank registers the
// prepared operands, so a result appears STAGES cycles after it is accepted.
// Optional feature macro: CLA_PIPE_OVF_EN adds the signed overflow output ovf.
module cla_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / 4;

    // One segment of lookahead addition. Group P/G feed a flat sum-of-products
    // group-carry network, and bit carries inside each group are also expanded
    // from that group's carry-in. Returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  c;
        logic [NGRP-1:0] gp;
        logic [NGRP-1:0] gg;
        logic [NGRP:0]   gen;
        logic [NGRP:0]   gc;
        logic            term;
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gen = {gg, ci};
        for (int j = 0; j <= NGRP; j++) begin
            gc[j] = 1'b0;
            for (int i = 0; i <= j; i++) begin
                term = gen[i];
                for (int k = i; k < j; k++) begin
                    term = term & gp[k];
                end
                gc[j] = gc[j] | term;
            end
        end
        for (int j = 0; j < NGRP; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[NGRP], p ^ c};
    endfunction

    // Rank 0 holds the prepared inputs; rank k+1 holds the output of stage k.
    logic [STAGES:0]  vld;
    logic [STAGES:0]  cry;
    logic [WIDTH-1:0] acc     [STAGES+1];
    logic [WIDTH-1:0] ra      [STAGES];
    logic [WIDTH-1:0] rb      [STAGES];
    logic [WIDTH-1:0] nxt_acc [STAGES];
    logic [SEG:0]     seg_res [STAGES];
    logic [STAGES-1:0] nxt_cry;
    logic             adv;
    logic             load;

    // The whole pipe moves together; a flush freezes the data so sum/cout keep their last value.
    assign adv      = ~vld[STAGES] | out_ready;
    assign load     = adv & ~flush;
    assign in_ready = adv;

    assign out_valid = vld[STAGES];
    assign sum       = acc[STAGES];
    assign cout      = cry[STAGES];

    // Each stage resolves its own segment and splices it into the partial sum carried along.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = seg_add(ra[k][k*SEG +: SEG], rb[k][k*SEG +: SEG], cry[k]);
            nxt_acc[k] = acc[k];
            nxt_acc[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
            nxt_cry[k] = seg_res[k][SEG];
        end
    end

    // Pipeline registers: valid bits shift on advance (cleared by flush), data moves only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            cry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                acc[k] <= '0;
            end
        end else begin
            if (flush) begin
                vld <= '0;
            end else if (adv) begin
                vld <= {vld[STAGES-1:0], in_valid};
            end
            if (load) begin
                ra[0]  <= op1;
                rb[0]  <= sub ? ~op2 : op2;
                cry[0] <= sub | cin;
                acc[0] <= '0;
                for (int k = 1; k < STAGES; k++) begin
                    ra[k] <= ra[k-1];
                    rb[k] <= rb[k-1];
                end
                for (int k = 1; k <= STAGES; k++) begin
                    acc[k] <= nxt_acc[k-1];
                    cry[k] <= nxt_cry[k-1];
                end
            end
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic nxt_ovf;
    logic ovf_q;

    // Carry into the MSB is recovered as a^b'^sum at that bit, then XORed with carry-out.
    assign nxt_ovf = ra[STAGES-1][WIDTH-1] ^ rb[STAGES-1][WIDTH-1]
                   ^ nxt_acc[STAGES-1][WIDTH-1] ^ nxt_cry[STAGES-1];
    assign ovf     = ovf_q;

    // Overflow flag travels with the final rank and is held under stall and flush like sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= nxt_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: directed, table-driven self-checking bench for cla_pipe (WIDTH=64, STAGES=4).
// Covers CLA_PIPE_OVF_EN when that macro is defined for the build.
module tb_cla_pipe;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic        sb;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    logic mon_en = 1'b0;
    logic pat_en = 1'b0;
    int   pcyc   = 0;
    logic [3:0] pat = 4'b1001;
    vec_t tbl[12];

    cla_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) pcyc <= pcyc + 1;

    assign out_ready = pat_en ? pat[pcyc % 4] : 1'b1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    function automatic res_t ref_model(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb);
        res_t r;
        logic [64:0] full;
        if (sb) begin
            r.s  = a - b;
            r.co = (a >= b);
            r.ov = (a[63] != b[63]) && (r.s[63] != a[63]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
            r.s  = full[63:0];
            r.co = full[64];
            r.ov = (a[63] == b[63]) && (r.s[63] != a[63]);
        end
        return r;
    endfunction

    // Present one operation at a negedge, wait (bounded) for acceptance, queue its expected result.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic ci,
                                 input logic sb, input logic keep, input res_t exp);
        int   waitc = 0;
        logic done  = 1'b0;
        in_valid = 1'b1;
        op1 = a;
        op2 = b;
        cin = ci;
        sub = sb;
        while (!done && waitc < 50) begin
            #1;
            if (in_ready) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                waitc++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0 want 1");
            @(negedge clk);
        end else begin
            @(posedge clk);
            if (keep) exp_q.push_back(exp);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d results outstanding want 0", exp_q.size());
        end
    endtask

    // Scoreboard: every visible result is compared against the head of the expected queue.
    always begin
        @(negedge clk);
        #3;
        if (mon_en && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_result: out_valid=1 sum=%h want no result", sum);
            end else begin
                checkOutput("sum", sum, exp_q[0].s);
                checkOutput("cout", 64'(cout), 64'(exp_q[0].co));
`ifdef CLA_PIPE_OVF_EN
                checkOutput("ovf", 64'(ovf), 64'(exp_q[0].ov));
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
            if (!out_ready) checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        res_t r;
        tbl[0]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        tbl[2]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[3]  = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        tbl[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        tbl[6]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
        tbl[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        tbl[8]  = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
        tbl[9]  = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h7, 1'b1, 1'b0};
        tbl[10] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 1'b0, 64'h0000_0000_0001_0001, 1'b0, 1'b0};
        tbl[11] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        op1 = '0; op2 = '0; cin = 1'b0; sub = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_sum", sum, 64'd0);
        checkOutput("reset_cout", 64'(cout), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef CLA_PIPE_OVF_EN
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Latency: accepted at one edge, visible exactly STAGES edges later.
        r = '{64'h0000_0001_0000_0000, 1'b0, 1'b0};
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, r);
        in_valid = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            #3;
            checkOutput("latency_early", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        #3;
        checkOutput("latency_due", 64'(out_valid), 64'd1);
        @(negedge clk);
        drain();

        // Table of directed vectors streamed back to back.
        for (int i = 0; i < 12; i++) begin
            r = '{tbl[i].s, tbl[i].co, tbl[i].ov};
            applyStimulus(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, 1'b1, r);
        end
        in_valid = 1'b0;
        drain();

        // Random stream with out_ready toggling 1,0,0,1.
        pat_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            logic        ci;
            logic        sb;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            applyStimulus(a, b, ci, sb, 1'b1, ref_model(a, b, ci, sb));
        end
        in_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        pat_en = 1'b0;
        @(negedge clk);

        // Flush with three ops in flight plus one presented on the flush cycle.
        r = '{64'h0, 1'b0, 1'b0};
        applyStimulus(64'h11, 64'h22, 1'b0, 1'b0, 1'b0, r);
        applyStimulus(64'h33, 64'h44, 1'b0, 1'b0, 1'b0, r);
        applyStimulus(64'h55, 64'h66, 1'b0, 1'b0, 1'b0, r);
        op1 = 64'h77; op2 = 64'h88; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            #3;
            checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        r = ref_model(64'h100, 64'h23, 1'b0, 1'b1);
        applyStimulus(64'h100, 64'h23, 1'b0, 1'b1, 1'b1, r);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) begin
            logic [63:0] a;
            a = 64'(i) * 64'h0101_0101_0101_0101;
            applyStimulus(a, 64'hFF, 1'b0, 1'b0, 1'b1, ref_model(a, 64'hFF, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
        #2;
        mon_en = 1'b0;
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset_sum", sum, 64'd0);
        checkOutput("async_reset_cout", 64'(cout), 64'd0);
        checkOutput("async_reset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < STAGES + 1; i++) begin
            @(negedge clk);
            #3;
            checkOutput("post_reset_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        r = ref_model(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, r);
        in_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor, the successor to the fixed 64-bit combinational CLA.
- Operand width is split into STAGES equal segments. Each segment is a chain of 4-bit lookahead groups.
- The inter-segment carry and the not-yet-consumed upper operand bits are registered.
- Valid/ready handshake on both ends. Sits in the multiplication unit as the final partial-product adder and as a general datapath adder.

Parameters:
- WIDTH, 64, operand/sum width. Must be a multiple of 4*STAGES.
- STAGES, 4, pipeline segments. 1 ≤ STAGES ≤ WIDTH/4.
- SEG, WIDTH/STAGES (localparam), bits resolved per stage.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept input this cycle
- op1  in  WIDTH  operand A
- op2  in  WIDTH  operand B
- cin  in  1  carry-in, add mode only
- sub  in  1  0: A+B+cin; 1: A−B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow)

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0, all data/carry registers 0. Outputs: out_valid=0, sum=0, cout=0, in_ready=1.
- Operand prep at input:
  - B' = sub ? ~op2 : op2.
  - c0 = sub ? 1 : cin.
  - No other transformation.
- Stage k (0..STAGES−1) adds bits [k*SEG+SEG−1 : k*SEG] of A and B' with the carry registered from stage k−1 (c0 for stage 0).
  - 4-bit groups inside a segment use lookahead (P/G per group, group carries from P/G), not ripple.
  - Stage k registers: its sum slice, its carry-out, the lower slices carried forward, and the A/B' slices still to be consumed.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+STAGES, when not stalled.
- Throughput: one result per cycle when out_ready is held high.
- Stall: global advance enable adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - When adv=0, every stage register holds its value. Bubbles are not collapsed.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/out_valid are stable.
- A bubble (in_valid=0 on an advancing cycle) shifts a 0 valid bit in. Data regs may update but are don't-care.
- flush=1: all valid bits cleared at next edge.
  - An input presented that cycle is discarded.
  - flush wins over simultaneous accept and over a held output.
  - sum/cout retain their last value.
- STAGES=1: single registered stage, latency 1.
- Wrap: sum is modulo 2^WIDTH, overflow out of MSB appears only on cout.
  - 0xFFFF…F + 1 → sum=0, cout=1.
- Reset asserted mid-operation: all in-flight results lost, state as reset.

Optional Feature:
- Macro CLA_PIPE_OVF_EN.
- When defined: extra output port ovf (1 bit), the signed two's-complement overflow, computed as carry-into-MSB XOR carry-out-of-MSB.
  - Pipelined alongside sum, valid with out_valid, 0 at reset, held under stall.
- When undefined: port and logic absent.
- Sum/cout behaviour is identical either way.

Test Plan:
- WIDTH=64, STAGES=4, out_ready=1: op1=0x0000_0000_FFFF_FFFF, op2=1, cin=0, sub=0 → 4 cycles later out_valid=1, sum=0x0000_0001_0000_0000, cout=0. Carry crosses segments 1→2.
- Full-width carry chain: op1=0xFFFF_FFFF_FFFF_FFFF, op2=0, cin=1 → sum=0, cout=1. With CLA_PIPE_OVF_EN: ovf=0.
- Subtract: op1=5, op2=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. op1=7, op2=5 → sum=2, cout=1.
- Back-to-back stream of 8 random ops, out_ready toggled 1,0,0,1,… → every result equals reference A±B. Order preserved, no drop or duplicate. in_ready=0 whenever out_valid=1 & out_ready=0.
- With CLA_PIPE_OVF_EN: op1=0x7FFF_FFFF_FFFF_FFFF, op2=1 → sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- 3 ops in flight, assert flush one cycle → out_valid stays 0 for the next 4 cycles. Separately, pull rst_n low mid-stream → out_valid=0 and sum=0 immediately (async), in_ready=1.
